// File: rtl/param_value_input_if.sv
// Key-entry bundle between a PS/2 byte source and param_value_input.
// The master drives key bytes; the slave returns the value and entry state.
interface param_value_input_if #(
  parameter int NUM_DIGITS = 3,
  parameter int VAL_WIDTH  = 10
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic                    Enable;
  logic [7:0]              data;
  logic                    data_en;
  logic [VAL_WIDTH-1:0]    Value;
  logic [4*NUM_DIGITS-1:0] Digits;
  logic [CNT_W-1:0]        Count;
  logic                    Editing;
  logic                    Busy;
  logic                    Commit;
  logic                    Clamped;

  modport master (
    output Enable, data, data_en,
    input  Value, Digits, Count,
    input  Editing, Busy, Commit, Clamped
  );

  modport slave (
    input  Enable, data, data_en,
    output Value, Digits, Count,
    output Editing, Busy, Commit, Clamped
  );
endinterface

// File: rtl/param_value_input.sv
// Decimal parameter entry from PS/2 scan codes with BCD buffer,
// serial BCD-to-binary conversion, clamped commit and KP+/KP- stepping.
module param_value_input #(
  parameter int NUM_DIGITS  = 3,
  parameter int VAL_WIDTH   = 10,
  parameter int MIN_VAL     = 20,
  parameter int MAX_VAL     = 300,
  parameter int DEFAULT_VAL = 120,
  parameter int STEP        = 1
) (
  input logic                Clock,
  input logic                Reset,
  param_value_input_if.slave bus
);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int ACC_W = $clog2(10 ** NUM_DIGITS);
  localparam int CMP_W =
    (ACC_W > VAL_WIDTH ? ACC_W : VAL_WIDTH) + 1;

  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_BS    = 8'h66;
  localparam logic [7:0] K_ESC   = 8'h76;
  localparam logic [7:0] K_PLUS  = 8'h79;
  localparam logic [7:0] K_MINUS = 8'h7B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EDIT,
    S_CONV,
    S_COMMIT
  } state_t;

  state_t               state_q, state_n;
  logic [DW-1:0]        digits_q, digits_n;
  logic [CNT_W-1:0]     count_q, count_n;
  logic [CNT_W-1:0]     idx_q, idx_n;
  logic [ACC_W-1:0]     acc_q, acc_n;
  logic [VAL_WIDTH-1:0] value_q, value_n;
  logic                 commit_q, commit_n;
  logic                 clamped_q, clamped_n;
  logic                 brk_q, brk_n;

  logic                 is_pfx;
  logic                 accept;
  logic                 is_dig;
  logic [3:0]           dig_val;
  logic [3:0]           cur_dig;
  logic [CMP_W-1:0]     acc_w;
  int                   up_i;
  int                   dn_i;

  always_comb begin
    is_dig  = 1'b1;
    dig_val = 4'd0;
    case (bus.data)
      8'h45, 8'h70: dig_val = 4'd0;
      8'h16, 8'h69: dig_val = 4'd1;
      8'h1E, 8'h72: dig_val = 4'd2;
      8'h26, 8'h7A: dig_val = 4'd3;
      8'h25, 8'h6B: dig_val = 4'd4;
      8'h2E, 8'h73: dig_val = 4'd5;
      8'h36, 8'h74: dig_val = 4'd6;
      8'h3D, 8'h6C: dig_val = 4'd7;
      8'h3E, 8'h75: dig_val = 4'd8;
      8'h46, 8'h7D: dig_val = 4'd9;
      default:      is_dig  = 1'b0;
    endcase
  end

  always_comb begin
    cur_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_q == CNT_W'(i))
        cur_dig = digits_q[4*i +: 4];
  end

  assign is_pfx = (bus.data == K_BRK) ||
                  (bus.data == K_EXT);
  assign accept = bus.data_en && !is_pfx && !brk_q;
  assign acc_w  = CMP_W'(acc_q);
  assign up_i   = int'(value_q) + STEP;
  assign dn_i   = int'(value_q) - STEP;

  always_comb begin
    state_n   = state_q;
    digits_n  = digits_q;
    count_n   = count_q;
    idx_n     = idx_q;
    acc_n     = acc_q;
    value_n   = value_q;
    commit_n  = 1'b0;
    clamped_n = clamped_q;
    brk_n     = brk_q;

    // break tracking runs regardless of state or Enable
    if (bus.data_en) begin
      if (bus.data == K_BRK)
        brk_n = 1'b1;
      else if (bus.data != K_EXT)
        brk_n = 1'b0;
    end

    if (!bus.Enable) begin
      state_n = S_IDLE;
      count_n = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && is_dig) begin
            digits_n = DW'(dig_val);
            count_n  = CNT_W'(1);
            state_n  = S_EDIT;
          end else if (accept && bus.data == K_PLUS) begin
            commit_n = 1'b1;
            if (up_i > MAX_VAL) begin
              value_n   = VAL_WIDTH'(MAX_VAL);
              clamped_n = 1'b1;
            end else begin
              value_n   = VAL_WIDTH'(up_i);
              clamped_n = 1'b0;
            end
          end else if (accept && bus.data == K_MINUS) begin
            commit_n = 1'b1;
            if (dn_i < MIN_VAL) begin
              value_n   = VAL_WIDTH'(MIN_VAL);
              clamped_n = 1'b1;
            end else begin
              value_n   = VAL_WIDTH'(dn_i);
              clamped_n = 1'b0;
            end
          end
        end
        S_EDIT: begin
          if (accept && is_dig) begin
            if (count_q < CNT_W'(NUM_DIGITS)) begin
              digits_n = DW'(digits_q << 4) | DW'(dig_val);
              count_n  = count_q + CNT_W'(1);
            end
          end else if (accept && bus.data == K_BS) begin
            digits_n = digits_q >> 4;
            count_n  = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1))
              state_n = S_IDLE;
          end else if (accept && bus.data == K_ESC) begin
            digits_n = '0;
            count_n  = '0;
            state_n  = S_IDLE;
          end else if (accept && bus.data == K_ENTER) begin
            acc_n   = '0;
            idx_n   = count_q - CNT_W'(1);
            state_n = S_CONV;
          end
        end
        S_CONV: begin
          // most significant digit first, one per cycle
          acc_n = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(cur_dig);
          idx_n = idx_q - CNT_W'(1);
          if (idx_q == '0)
            state_n = S_COMMIT;
        end
        S_COMMIT: begin
          commit_n = 1'b1;
          count_n  = '0;
          state_n  = S_IDLE;
          if (acc_w < CMP_W'(MIN_VAL)) begin
            value_n   = VAL_WIDTH'(MIN_VAL);
            clamped_n = 1'b1;
          end else if (acc_w > CMP_W'(MAX_VAL)) begin
            value_n   = VAL_WIDTH'(MAX_VAL);
            clamped_n = 1'b1;
          end else begin
            value_n   = VAL_WIDTH'(acc_q);
            clamped_n = 1'b0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      value_q   <= VAL_WIDTH'(DEFAULT_VAL);
      commit_q  <= 1'b0;
      clamped_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      digits_q  <= digits_n;
      count_q   <= count_n;
      idx_q     <= idx_n;
      acc_q     <= acc_n;
      value_q   <= value_n;
      commit_q  <= commit_n;
      clamped_q <= clamped_n;
      brk_q     <= brk_n;
    end
  end

  assign bus.Value   = value_q;
  assign bus.Digits  = digits_q;
  assign bus.Count   = count_q;
  assign bus.Commit  = commit_q;
  assign bus.Clamped = clamped_q;
  assign bus.Editing = (state_q == S_EDIT);
  assign bus.Busy    = (state_q == S_CONV) ||
                       (state_q == S_COMMIT);
endmodule

// File: tb/tb_param_value_input.sv
// Bench for param_value_input: key-sequence table, timing corner
// cases and random keystrokes against a decimal-entry model.
module tb_param_value_input;
  localparam int ND   = 3;
  localparam int VW   = 10;
  localparam int MINV = 20;
  localparam int MAXV = 300;
  localparam int DEFV = 120;
  localparam int STP  = 1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   ncommit = 0;
  int   base  = 0;

  param_value_input_if #(.NUM_DIGITS(ND), .VAL_WIDTH(VW)) bus ();

  param_value_input #(
    .NUM_DIGITS(ND), .VAL_WIDTH(VW), .MIN_VAL(MINV),
    .MAX_VAL(MAXV), .DEFAULT_VAL(DEFV), .STEP(STP)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock)
    if (bus.Commit === 1'b1) ncommit <= ncommit + 1;

  typedef struct {
    logic [7:0] key;
    int v; int cl; int cnt; int dig; int ed; int cm;
  } vec_t;
  vec_t tbl [30];

  logic [7:0] main_c [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] kp_c [10]   = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                              8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  int m_v, m_cl, m_cnt, m_ed, m_cm;
  int m_dig [ND];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic snap(input string tag, input int v, input int cl,
                      input int cnt, input int dig, input int ed,
                      input int cm);
    chk({tag, " Value"}, int'(bus.Value), v);
    chk({tag, " Clamped"}, int'(bus.Clamped), cl);
    chk({tag, " Count"}, int'(bus.Count), cnt);
    chk({tag, " Digits"}, int'(bus.Digits), dig);
    chk({tag, " Editing"}, int'(bus.Editing), ed);
    chk({tag, " Commits"}, ncommit - base, cm);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clock);
    bus.data = b;
    bus.data_en = 1'b1;
    @(negedge Clock);
    bus.data_en = 1'b0;
  endtask

  task automatic press(input logic [7:0] c, input bit e0);
    if (e0) send_byte(8'hE0);
    send_byte(c);
    send_byte(8'hF0);
    send_byte(c);
    repeat (4) @(negedge Clock);
  endtask

  task automatic do_reset();
    bus.Enable = 1'b1;
    bus.data_en = 1'b0;
    bus.data = 8'h00;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  // 0-9 digit, 10 BS, 11 ESC, 12 ENTER, 13 KP+, 14 KP-, 15 other
  task automatic model_key(input int k);
    int n;
    if (k <= 9) begin
      if (m_ed == 0) begin
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        m_dig[0] = k; m_cnt = 1; m_ed = 1;
      end else if (m_cnt < ND) begin
        for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
        m_dig[0] = k; m_cnt++;
      end
    end else if (k == 10 && m_ed == 1) begin
      for (int i = 0; i < ND - 1; i++) m_dig[i] = m_dig[i+1];
      m_dig[ND-1] = 0; m_cnt--;
      if (m_cnt == 0) m_ed = 0;
    end else if (k == 11 && m_ed == 1) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      m_cnt = 0; m_ed = 0;
    end else if (k == 12 && m_ed == 1) begin
      n = 0;
      for (int i = m_cnt - 1; i >= 0; i--) n = n * 10 + m_dig[i];
      m_cl = (n < MINV || n > MAXV) ? 1 : 0;
      m_v = n < MINV ? MINV : (n > MAXV ? MAXV : n);
      m_cnt = 0; m_ed = 0; m_cm++;
    end else if ((k == 13 || k == 14) && m_ed == 0) begin
      n = (k == 13) ? m_v + STP : m_v - STP;
      m_cl = (n < MINV || n > MAXV) ? 1 : 0;
      m_v = n < MINV ? MINV : (n > MAXV ? MAXV : n);
      m_cm++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n, cm_edge, hits, v4, v5, k, pd;
    logic [7:0] code;
    tbl = '{
      '{8'h16, 120, 0, 1, 'h001, 1, 0}, '{8'h1E, 120, 0, 2, 'h012, 1, 0},
      '{8'h3E, 120, 0, 3, 'h128, 1, 0}, '{8'h5A, 128, 0, 0, 'h128, 0, 1},
      '{8'h46, 128, 0, 1, 'h009, 1, 1}, '{8'h46, 128, 0, 2, 'h099, 1, 1},
      '{8'h46, 128, 0, 3, 'h999, 1, 1}, '{8'h5A, 300, 1, 0, 'h999, 0, 2},
      '{8'h2E, 300, 1, 1, 'h005, 1, 2}, '{8'h5A,  20, 1, 0, 'h005, 0, 3},
      '{8'h16,  20, 1, 1, 'h001, 1, 3}, '{8'h1E,  20, 1, 2, 'h012, 1, 3},
      '{8'h26,  20, 1, 3, 'h123, 1, 3}, '{8'h25,  20, 1, 3, 'h123, 1, 3},
      '{8'h66,  20, 1, 2, 'h012, 1, 3}, '{8'h76,  20, 1, 0, 'h000, 0, 3},
      '{8'h1E,  20, 1, 1, 'h002, 1, 3}, '{8'h46,  20, 1, 2, 'h029, 1, 3},
      '{8'h46,  20, 1, 3, 'h299, 1, 3}, '{8'h5A, 299, 0, 0, 'h299, 0, 4},
      '{8'h79, 300, 0, 0, 'h299, 0, 5}, '{8'h79, 300, 1, 0, 'h299, 0, 6},
      '{8'h7B, 299, 0, 0, 'h299, 0, 7}, '{8'h5A, 299, 0, 0, 'h299, 0, 7},
      '{8'h6C, 299, 0, 1, 'h007, 1, 7}, '{8'h66, 299, 0, 0, 'h000, 0, 7},
      '{8'h70, 299, 0, 1, 'h000, 1, 7}, '{8'h5A,  20, 1, 0, 'h000, 0, 8},
      '{8'h7B,  20, 1, 0, 'h000, 0, 9}, '{8'h79,  21, 0, 0, 'h000, 0, 10}
    };

    do_reset();
    base = ncommit;
    snap("reset", DEFV, 0, 0, 0, 0, 0);
    chk("reset Busy", int'(bus.Busy), 0);
    chk("reset Commit", int'(bus.Commit), 0);

    for (int i = 0; i < 30; i++) begin
      press(tbl[i].key, 1'b0);
      snap($sformatf("row%0d", i), tbl[i].v, tbl[i].cl,
           tbl[i].cnt, tbl[i].dig, tbl[i].ed, tbl[i].cm);
    end

    // ENTER latency: Busy Count+1 cycles, Commit after edge Count+2
    do_reset();
    press(8'h16, 1'b0); press(8'h1E, 1'b0); press(8'h3E, 1'b0);
    chk("lat Digits", int'(bus.Digits), 'h128);
    send_byte(8'h5A);
    busy_n = 0; cm_edge = 0; hits = 0; v4 = 0; v5 = 0;
    for (int e = 1; e <= 8; e++) begin
      if (bus.Busy === 1'b1) busy_n++;
      if (bus.Commit === 1'b1) begin
        hits++;
        if (cm_edge == 0) cm_edge = e;
      end
      if (e == 4) v4 = int'(bus.Value);
      if (e == 5) v5 = int'(bus.Value);
      @(negedge Clock);
    end
    chk("lat Busy cycles", busy_n, 4);
    chk("lat Commit edge", cm_edge, 5);
    chk("lat Commit pulses", hits, 1);
    chk("lat Value before", v4, DEFV);
    chk("lat Value after", v5, 128);
    chk("lat Clamped", int'(bus.Clamped), 0);

    // reset asserted mid-conversion
    do_reset();
    press(8'h16, 1'b0); press(8'h1E, 1'b0); press(8'h3E, 1'b0);
    send_byte(8'h5A);
    chk("rstconv Busy", int'(bus.Busy), 1);
    base = ncommit;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (8) @(negedge Clock);
    snap("rstconv", DEFV, 0, 0, 0, 0, 0);
    chk("rstconv Busy after", int'(bus.Busy), 0);

    // Enable dropped during EDIT
    do_reset();
    base = ncommit;
    press(8'h16, 1'b0); press(8'h1E, 1'b0);
    chk("en Editing", int'(bus.Editing), 1);
    bus.Enable = 1'b0;
    repeat (2) @(negedge Clock);
    snap("en low", DEFV, 0, 0, 'h012, 0, 0);
    bus.Enable = 1'b1;
    press(8'h5A, 1'b0);
    snap("en enter", DEFV, 0, 0, 'h012, 0, 0);

    // Enable dropped during CONVERT
    press(8'h16, 1'b0); press(8'h1E, 1'b0);
    send_byte(8'h5A);
    bus.Enable = 1'b0;
    repeat (6) @(negedge Clock);
    bus.Enable = 1'b1;
    @(negedge Clock);
    snap("en conv", DEFV, 0, 0, 'h012, 0, 0);
    chk("en conv Busy", int'(bus.Busy), 0);

    // lone break and extended prefix
    do_reset();
    base = ncommit;
    send_byte(8'hF0); send_byte(8'h16);
    repeat (2) @(negedge Clock);
    snap("lone brk", DEFV, 0, 0, 0, 0, 0);
    send_byte(8'hE0); send_byte(8'h70);
    repeat (2) @(negedge Clock);
    snap("ext kp0", DEFV, 0, 1, 0, 1, 0);

    // random keystrokes against the model
    do_reset();
    base = ncommit;
    m_v = DEFV; m_cl = 0; m_cnt = 0; m_ed = 0; m_cm = 0;
    for (int i = 0; i < ND; i++) m_dig[i] = 0;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 19);
      if (k < 10) begin
        k = $urandom_range(0, 9);
        code = ($urandom_range(0, 1) == 1) ? kp_c[k] : main_c[k];
        press(code, $urandom_range(0, 3) == 0);
      end else begin
        k = (k < 14) ? 10 + (k - 10) / 2 : k - 2;
        if (k > 15) k = 12;
        case (k)
          10: code = 8'h66;
          11: code = 8'h76;
          12: code = 8'h5A;
          13: code = 8'h79;
          14: code = 8'h7B;
          default: code = 8'h1C;
        endcase
        press(code, 1'b0);
      end
      model_key(k);
      pd = 0;
      for (int i = 0; i < ND; i++) pd |= m_dig[i] << (4 * i);
      snap($sformatf("rnd%0d", n), m_v, m_cl, m_cnt, pd, m_ed, m_cm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_value_input.md
PARAM_VALUE_INPUT -- requirements
Module: param_value_input

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_DIGITS, 3, max decimal digits entered.
REQ-002 VAL_WIDTH, 10, width of Value.
REQ-003 MIN_VAL, 20; MAX_VAL, 300; DEFAULT_VAL, 120: commit clamp range and reset value; legal only if MIN_VAL <= DEFAULT_VAL <= MAX_VAL < 2^VAL_WIDTH.
REQ-004 STEP, 1: increment/decrement amount for KP+/KP- keys.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset. Ports (name, direction, width, meaning):
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Enable  in  1  key processing enable
- data  in  8  PS/2 scan code byte
- data_en  in  1  data valid, one cycle per byte
- Value  out  VAL_WIDTH  committed value
- Digits  out  4*NUM_DIGITS  live BCD entry buffer; digit 0 (ones) in [3:0]
- Count  out  clog2(NUM_DIGITS+1)  digits currently entered
- Editing  out  1  high in EDIT state
- Busy  out  1  high in CONVERT or COMMIT state
- Commit  out  1  one-cycle pulse when Value is written
- Clamped  out  1  registered; set when the last Value write was clamped or saturated

Function
REQ-006 Scan-code decode: 0xF0 SHALL set a break flag, and the next non-prefix byte SHALL be consumed without action, clearing the flag. 0xE0 SHALL be ignored as a prefix. A byte is "accepted" only when data_en=1, it is not a prefix, and the break flag is clear.
REQ-007 Digit keys SHALL be main row 0x45,16,1E,26,25,2E,36,3D,3E,46 (0-9) and keypad 0x70,69,72,7A,6B,73,74,6C,75,7D (0-9). Other keys: ENTER 0x5A, BACKSPACE 0x66, ESC 0x76, KP+ 0x79, KP- 0x7B.
REQ-008 The state machine SHALL have the states IDLE, EDIT, CONVERT and COMMIT.
REQ-009 IDLE, digit accepted: Digits SHALL clear and the digit loads into position 0; Count=1; state goes to EDIT.
REQ-010 IDLE, KP+ or KP- accepted: at that same edge Value SHALL become Value±STEP saturated to [MIN_VAL, MAX_VAL]; Commit pulses; Clamped=1 iff saturation occurred. ENTER, BACKSPACE and ESC in IDLE SHALL be ignored.
REQ-011 EDIT, digit accepted with Count<NUM_DIGITS: Digits SHALL shift up one position, the new digit enters position 0, and Count increments. With Count=NUM_DIGITS the digit SHALL be ignored.
REQ-012 EDIT, BACKSPACE: Digits SHALL shift down with the top position zero-filled, and Count decrements. If the result is Count=0, state goes to IDLE.
REQ-013 EDIT, ESC: Digits and Count SHALL clear and state goes to IDLE; Value and Clamped are unchanged; no Commit.
REQ-014 EDIT, ENTER: state SHALL go to CONVERT, with the accumulator cleared and the index set to Count-1.
REQ-015 CONVERT: each cycle SHALL perform acc=acc*10+Digits[index] and decrement the index. After Count cycles the state goes to COMMIT. The accumulator SHALL be at least clog2(10^NUM_DIGITS) bits wide, so there is no overflow.
REQ-016 COMMIT: Value SHALL be set to acc clamped to [MIN_VAL, MAX_VAL], with the compare done at full accumulator width before truncation. Clamped=1 iff clamped. Commit pulses for one cycle. State goes to IDLE; Digits are retained; Count clears.
REQ-017 Latency: Commit and the new Value SHALL be visible after edge Count+2, counting the ENTER-accepting edge as edge 1.
REQ-018 Accepted bytes arriving in CONVERT or COMMIT SHALL be dropped. Break/prefix tracking SHALL still run.
REQ-019 Enable=0: state SHALL be forced to IDLE with Count=0. An in-flight CONVERT is aborted with no Commit. Value, Digits and Clamped are held. Keys are ignored; break tracking still runs.
REQ-020 Editing SHALL equal (state==EDIT), and Busy SHALL equal (state==CONVERT or COMMIT); both registered-state decodes.

Reset
REQ-021 On Reset=1, asynchronously: Value=DEFAULT_VAL, Digits=0, Count=0, Commit=0, Clamped=0, state=IDLE, break flag=0. This SHALL also apply mid-operation, with no pending Commit after release.

Verification (defaults)
REQ-022 Reset, then the make/break sequences for 1,2,8 followed by ENTER -> Digits=0x128; Busy for 4 cycles; Commit pulses once after edge 5; Value=128; Clamped=0.
REQ-023 Keys 9,9,9 then ENTER -> Value=300, Clamped=1. Then key 5 then ENTER -> Value=20, Clamped=1.
REQ-024 Keys 1,2,3,4 -> Digits=0x123, Count=3. Then BACKSPACE -> Digits=0x012, Count=2. Then ESC -> Count=0, Editing=0, Value unchanged, no Commit.
REQ-025 In IDLE with Value=299: KP+ -> Value=300, Commit; KP+ again -> Value=300, Clamped=1; then KP- -> Value=299, Clamped=0.
REQ-026 Lone sequence F0 16 -> no digit entered. Sequence E0 70 -> digit 0 entered, Count=1.
REQ-027 Reset pulsed during CONVERT -> Value=120 and no Commit. Enable dropped during EDIT, then ENTER with Enable=1 -> no Commit and Count=0.
